// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2/stride-2 max/average pooling with argmax index,
// buffering only one partial pair per output column across the even/odd row pair.
module pool2x2_stream #(
    parameter int DW      = 16,
    parameter int OUT_DIM = 3,
    localparam int AW     = (OUT_DIM * OUT_DIM > 1) ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic [AW-1:0] out_addr,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    localparam int IN_DIM = 2 * OUT_DIM;
    localparam int CW     = $clog2(IN_DIM);
    localparam int PW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int LAST   = OUT_DIM * OUT_DIM - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d, px_done_q, px_done_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [DW-1:0] a_q, a_d, c_q, c_d;
    logic [DW:0]   partial_q [OUT_DIM];
    logic [DW:0]   partial_d [OUT_DIM];
    logic          out_valid_q, out_valid_d, done_q, done_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_idx_q, out_idx_d;
    logic [AW-1:0] out_addr_q, out_addr_d;

    logic          in_fire, out_fire, last_col, last_row, last_out;
    logic [PW-1:0] pidx;
    logic [DW:0]   pair, part;
    logic [DW-1:0] mv1, mv;
    logic [1:0]    mi1, mi;
    logic [DW+1:0] sum;

    assign in_ready = (state_q == RUN) && !px_done_q && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign last_col = col_q == CW'(IN_DIM - 1);
    assign last_row = row_q == CW'(IN_DIM - 1);
    assign last_out = out_addr_q == AW'(LAST);
    assign pidx     = PW'(col_q >> 1);
    assign part     = partial_q[pidx];

    // Partial word holds {idx, max} in max mode, or the (DW+1)-bit pair sum in avg mode
    assign pair = mode_q ? ({1'b0, a_q} + {1'b0, in_data})
                         : (in_data > a_q ? {1'b1, in_data} : {1'b0, a_q});
    assign mv1  = c_q > part[DW-1:0] ? c_q : part[DW-1:0];
    assign mi1  = c_q > part[DW-1:0] ? 2'd2 : {1'b0, part[DW]};
    assign mv   = in_data > mv1 ? in_data : mv1;
    assign mi   = in_data > mv1 ? 2'd3 : mi1;
    assign sum  = (DW+2)'(part) + (DW+2)'(c_q) + (DW+2)'(in_data);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        px_done_d   = px_done_q;
        row_d       = row_q;
        col_d       = col_q;
        a_d         = a_q;
        c_d         = c_q;
        partial_d   = partial_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;
        if (state_q == IDLE && start) begin
            state_d    = RUN;
            mode_d     = mode;
            px_done_d  = 1'b0;
            row_d      = '0;
            col_d      = '0;
            out_addr_d = '0;
        end
        if (in_fire) begin
            col_d     = last_col ? '0 : col_q + 1'b1;
            row_d     = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
            px_done_d = last_col && last_row;
            if (!row_q[0] && !col_q[0]) a_d = in_data;
            if (!row_q[0] && col_q[0]) partial_d[pidx] = pair;
            if (row_q[0] && !col_q[0]) c_d = in_data;
        end
        if (out_fire) begin
            out_valid_d = 1'b0;
            out_addr_d  = last_out ? '0 : out_addr_q + 1'b1;
            state_d     = last_out ? IDLE : state_d;
            done_d      = last_out;
        end
        // A new result may load in the same cycle the previous one drains
        if (in_fire && row_q[0] && col_q[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = mode_q ? sum[DW+1:2] : mv;
            out_idx_d   = mode_q ? 2'd0 : mi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            px_done_q   <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            a_q         <= '0;
            c_q         <= '0;
            for (int i = 0; i < OUT_DIM; i++) partial_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            px_done_q   <= px_done_d;
            row_q       <= row_d;
            col_q       <= col_d;
            a_q         <= a_d;
            c_q         <= c_d;
            partial_q   <= partial_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_addr  = out_addr_q;
    assign busy      = state_q == RUN;
    assign done      = done_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: randomized frames checked against a window-level pooling model,
// with literal pins for ramp, tie, saturation, stall and mid-frame reset cases.
module tb_pool2x2_stream;
    logic        clk = 1'b0;
    logic        rst_n, start, mode, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [15:0] in_data, out_data;
    logic [1:0]  out_idx;
    logic [3:0]  out_addr;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  i;
        logic [3:0]  a;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] img[36];
    int          tests = 0;
    int          fails = 0;
    bit          done_pend = 0;

    pool2x2_stream #(.DW(16), .OUT_DIM(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_addr(out_addr), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-frame reference: each output is a plain max/mean over its 2x2 window
    task automatic model(input bit m);
        exp_q.delete();
        for (int oy = 0; oy < 3; oy++) begin
            for (int ox = 0; ox < 3; ox++) begin
                int   w[4];
                int   best, bi, s;
                res_t r;
                w[0] = int'(img[(2*oy)*6 + 2*ox]);
                w[1] = int'(img[(2*oy)*6 + 2*ox + 1]);
                w[2] = int'(img[(2*oy+1)*6 + 2*ox]);
                w[3] = int'(img[(2*oy+1)*6 + 2*ox + 1]);
                best = w[0];
                bi   = 0;
                s    = 0;
                for (int k = 0; k < 4; k++) begin
                    s += w[k];
                    if (w[k] > best) begin
                        best = w[k];
                        bi   = k;
                    end
                end
                r.d = m ? 16'(s >> 2) : 16'(best);
                r.i = m ? 2'd0 : 2'(bi);
                r.a = 4'(oy*3 + ox);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic pin(input string nm, input int dv[9], input int iv[9]);
        for (int k = 0; k < 9; k++) begin
            chk({nm, "_data"}, 32'(exp_q[k].d), dv[k]);
            chk({nm, "_idx"}, 32'(exp_q[k].i), iv[k]);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
    endtask

    task automatic run_frame(input bit m, input int vp, input int rp, input bit stall,
                             input int abort_at, input bit rnd_ctl);
        int pix = 0;
        int cyc = 0;
        int stall_left;
        bit got_done = 0;
        stall_left = stall ? 5 : 0;
        @(posedge clk); #1;
        start = 1'b1; mode = m; in_valid = 1'b0; out_ready = 1'b1;
        while (!got_done && cyc < 3000) begin
            @(posedge clk); #1;
            start    = rnd_ctl && pix < 36 && $urandom_range(7) == 0;
            if (rnd_ctl) mode = 1'($urandom_range(1));
            in_valid = pix < 36 && $urandom_range(99) < vp;
            in_data  = pix < 36 ? img[pix] : 16'($urandom);
            if (stall_left > 0 && out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = $urandom_range(99) < rp;
            @(negedge clk);
            cyc++;
            if (stall && !out_ready && out_valid) chk("stall_in_ready", 32'(in_ready), 0);
            if (pix == 36) chk("in_ready_after_last", 32'(in_ready), 0);
            chk("busy", 32'(busy), 32'(!done));
            if (done) got_done = 1;
            if (in_valid && in_ready) begin
                pix++;
                if (pix == abort_at) begin
                    @(posedge clk); #1;
                    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
                    exp_q.delete();
                    repeat (2) @(negedge clk);
                    check_reset_outs();
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
            end
        end
        start = 1'b0; in_valid = 1'b0;
        chk("frame_done_seen", 32'(got_done), 1);
        chk("results_drained", 32'(exp_q.size()), 0);
        if (stall) chk("stall_applied", 32'(stall_left), 0);
    endtask

    // Compare process: every cycle with rst_n high, outputs must match the queue head
    always @(negedge clk) begin
        if (!rst_n) done_pend = 0;
        else begin
            chk("done", 32'(done), 32'(done_pend));
            done_pend = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 0);
                else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0].d));
                    chk("out_idx", 32'(out_idx), 32'(exp_q[0].i));
                    chk("out_addr", 32'(out_addr), 32'(exp_q[0].a));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_pend = 1;
                    end
                end
            end
        end
    end

    initial begin
        int t_max[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        int t_avg[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        int i3[9]    = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        int i0[9]    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ff[9]    = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 36; k++) img[k] = 16'(k);
        model(0);
        pin("ramp_max", t_max, i3);
        run_frame(0, 100, 100, 0, -1, 0);

        model(1);
        pin("ramp_avg", t_avg, i0);
        run_frame(1, 100, 100, 0, -1, 0);

        for (int k = 0; k < 36; k++) img[k] = 16'($urandom);
        img[0] = 5; img[1] = 5; img[6] = 5; img[7] = 5;
        img[2] = 1; img[3] = 2; img[8] = 9; img[9] = 3;
        model(0);
        chk("tie_data", 32'(exp_q[0].d), 5);
        chk("tie_idx", 32'(exp_q[0].i), 0);
        chk("bl_data", 32'(exp_q[1].d), 9);
        chk("bl_idx", 32'(exp_q[1].i), 2);
        run_frame(0, 70, 70, 0, -1, 0);

        for (int k = 0; k < 36; k++) img[k] = 16'hFFFF;
        model(1);
        pin("sat_avg", ff, i0);
        run_frame(1, 70, 70, 0, -1, 1);

        for (int k = 0; k < 36; k++) img[k] = 16'(k);
        model(0);
        run_frame(0, 100, 100, 1, -1, 0);

        model(0);
        run_frame(0, 70, 70, 0, 20, 0);
        model(0);
        pin("post_reset_max", t_max, i3);
        run_frame(0, 100, 100, 0, -1, 0);

        for (int f = 0; f < 4; f++) begin
            bit m;
            m = 1'($urandom_range(1));
            for (int k = 0; k < 36; k++) img[k] = 16'($urandom);
            model(m);
            run_frame(m, 60, 60, 0, -1, 1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
